adder_sweep_checker: RTL and testbench

Self-checking sequential stimulus/response block for the team's combinational W-bit adders. It exhaustively drives every {A, B, Cin} combination into a DUT adder and samples the DUT's {Cout, S} after a settle window. It compares each result against an internal golden sum and reports pass/fail, the error count and the first failing vector. It sits immediately around the adder under test, both feeding it and consuming its outputs, and is used on-board and in simulation.

---
 rtl/adder_chk_pkg.sv | 33 +++
 rtl/adder_sweep_checker_if.sv | 29 ++
 rtl/golden_add.sv | 21 ++
 rtl/adder_sweep_checker.sv | 136 +++++++++++++
 tb/tb_adder_sweep_checker.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_chk_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// adder_chk_pkg
// Shared types and sizing helpers for the adder sweep checker.
// Revision: 1.0
// ------------------------------------------------------------------
package adder_chk_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Vector index carries {A, B, Cin}
  function automatic int idx_width(input int w);
    return 2 * w + 1;
  endfunction

  // Number of vectors in a full sweep
  function automatic int vec_count(input int w);
    return 1 << (2 * w + 1);
  endfunction

  // One extra bit so a full sweep of mismatches still fits
  function automatic int err_width(input int w);
    return 2 * w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_sweep_checker_if.sv
`default_nettype none
// ------------------------------------------------------------------
// adder_sweep_checker_if
// Connection between the sweep checker (master) and the adder under
// test (slave): operands out, sum and carry back.
// Revision: 1.0
// ------------------------------------------------------------------
interface adder_sweep_checker_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_s;
  logic             dut_cout;

  modport master (
    output dut_a, dut_b, dut_cin,
    input  dut_s, dut_cout
  );

  modport slave (
    input  dut_a, dut_b, dut_cin,
    output dut_s, dut_cout
  );

endinterface
`default_nettype wire

// File: rtl/golden_add.sv
`default_nettype none
// ------------------------------------------------------------------
// golden_add
// Reference adder: {cout_o, s_o} = a_i + b_i + cin_i, full width.
// Revision: 1.0
// ------------------------------------------------------------------
module golden_add #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  input  wire logic             cin_i,
  output logic      [WIDTH-1:0] s_o,
  output logic                  cout_o
);

  // Operands widened by one bit so the carry is never truncated
  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/adder_sweep_checker.sv
`default_nettype none
// ------------------------------------------------------------------
// adder_sweep_checker
// Exhaustively drives every {A, B, Cin} into an adder under test,
// holds each vector SETTLE cycles, samples {cout, s} in a one-cycle
// CHECK state and compares against a golden sum. Reports pass, a
// saturating mismatch count and the first failing vector index.
// Build option: ADDER_CHK_STOP_ON_ERR_EN ends the sweep at the first
// mismatch.
// Revision: 1.0
// ------------------------------------------------------------------
module adder_sweep_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      start,
  adder_sweep_checker_if.master          dut_if,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [err_width(WIDTH)-1:0]    err_count,
  output logic [idx_width(WIDTH)-1:0]    first_err_vec
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam int ERR_W = err_width(WIDTH);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

`ifdef ADDER_CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [IDX_W-1:0] first_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [WIDTH-1:0] gold_s;
  logic             gold_cout;
  logic             mismatch;
  logic             last_vec;

  // Operands are slices of the index register, so the driven vector
  // is always registered and always the one being compared.
  assign dut_if.dut_a   = idx_q[IDX_W-1:WIDTH+1];
  assign dut_if.dut_b   = idx_q[WIDTH:1];
  assign dut_if.dut_cin = idx_q[0];

  golden_add #(.WIDTH(WIDTH)) u_golden (
    .a_i    (idx_q[IDX_W-1:WIDTH+1]),
    .b_i    (idx_q[WIDTH:1]),
    .cin_i  (idx_q[0]),
    .s_o    (gold_s),
    .cout_o (gold_cout)
  );

  assign mismatch = ({dut_if.dut_cout, dut_if.dut_s} != {gold_cout, gold_s});
  assign last_vec = (idx_q == {IDX_W{1'b1}});

  // Saturating next value of the mismatch counter
  assign err_d = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);

  // Sweep controller: sequence vectors, count mismatches, publish results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_DRIVE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_W'(SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_q <= err_d;
            if (err_q == '0) begin
              first_q <= idx_q;
            end
          end
          if (last_vec || (STOP_ON_ERR && mismatch)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !mismatch && (err_q == '0);
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= ST_DRIVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vec = first_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_sweep_checker.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_adder_sweep_checker
// Bench for adder_sweep_checker: a behavioural adder with selectable
// faults sits on the slave side; results are compared against a table
// of known outcomes and a vector-level model for random fault maps.
// Revision: 1.0
// ------------------------------------------------------------------
module tb_adder_sweep_checker;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;
  localparam int NVEC   = 1 << (2 * WIDTH + 1);
  localparam int CPV    = SETTLE + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [9:0]  err_count;
  logic [8:0]  first_err_vec;

  // 0: correct, 1: cout stuck 0, 2: s[0] inverted, 3: random fault map
  int          fault_mode = 0;
  bit          flt  [NVEC];
  logic [4:0]  fmask[NVEC];

  int          errors = 0;
  int          checks = 0;

  adder_sweep_checker_if #(.WIDTH(WIDTH)) bus ();

  adder_sweep_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dut_if        (bus.master),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_vec (first_err_vec)
  );

  always #5 clk = ~clk;

  // Adder under test with optional injected faults
  always_comb begin
    logic [4:0] v;
    int         idx;
    v   = 5'(int'(bus.dut_a) + int'(bus.dut_b) + int'(bus.dut_cin));
    idx = {bus.dut_a, bus.dut_b, bus.dut_cin};
    case (fault_mode)
      1: v[4] = 1'b0;
      2: v[0] = ~v[0];
      3: if (flt[idx]) v = v ^ fmask[idx];
      default: ;
    endcase
    {bus.dut_cout, bus.dut_s} = v;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outcome of a sweep over the random fault map
  task automatic model(output int e, output int f, output int cyc);
    bit stop;
    e = 0; f = 0; cyc = NVEC * CPV; stop = 0;
    for (int i = 0; i < NVEC; i++) begin
      if (!stop && flt[i]) begin
        if (e == 0) f = i;
        e++;
`ifdef ADDER_CHK_STOP_ON_ERR_EN
        cyc  = (i + 1) * CPV;
        stop = 1;
`endif
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_first"}, int'(first_err_vec), 0);
    check({tag, "_vec"}, int'({bus.dut_a, bus.dut_b, bus.dut_cin}), 0);
  endtask

  // One sweep from IDLE/DONE; returns busy cycles until done
  task automatic run_sweep(input int mode, input bit poke, output int cyc);
    fault_mode = mode;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_done", int'(done), 0);
    check("start_err", int'(err_count), 0);
    check("start_vec0", int'({bus.dut_a, bus.dut_b, bus.dut_cin}), 0);
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (busy) cyc++;
      if (poke) start = ((cyc % 7) == 3);
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL sweep_timeout: got done=%0d expected 1", done);
    end
  endtask

  typedef struct {
    int mode;
    int exp_err;
    int exp_first;
    int exp_pass;
    int exp_cyc;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc, e, f, c;

    tbl[0] = '{0, 0, 0, 1, NVEC * CPV};
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    tbl[1] = '{1, 1, 31, 0, 32 * CPV};
    tbl[2] = '{2, 1, 0, 0, 1 * CPV};
`else
    tbl[1] = '{1, 256, 31, 0, NVEC * CPV};
    tbl[2] = '{2, 512, 0, 0, NVEC * CPV};
`endif
    tbl[3] = '{0, 0, 0, 1, NVEC * CPV};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Table of fault modes, run back to back (each restart from DONE)
    for (int t = 0; t < 4; t++) begin
      run_sweep(tbl[t].mode, 1'b0, cyc);
      check("tbl_cycles", cyc, tbl[t].exp_cyc);
      check("tbl_err", int'(err_count), tbl[t].exp_err);
      if (tbl[t].exp_err != 0) check("tbl_first", int'(first_err_vec), tbl[t].exp_first);
      check("tbl_pass", int'(pass), tbl[t].exp_pass);
      check("tbl_busy_low", int'(busy), 0);
      @(negedge clk);
      check("tbl_done_held", int'(done), 1);
    end

    // Random fault maps against the model
    for (int r = 0; r < 4; r++) begin
      int dens;
      dens = (r == 3) ? 100000 : int'($urandom_range(2, 60));
      for (int i = 0; i < NVEC; i++) begin
        flt[i]   = ($urandom_range(0, dens) == 0);
        fmask[i] = 5'($urandom_range(1, 31));
      end
      model(e, f, c);
      run_sweep(3, 1'b0, cyc);
      check("rnd_cycles", cyc, c);
      check("rnd_err", int'(err_count), e);
      if (e != 0) check("rnd_first", int'(first_err_vec), f);
      check("rnd_pass", int'(pass), (e == 0) ? 1 : 0);
    end

    // Reset mid-sweep, then a clean sweep
    fault_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (299) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst_idle", int'(busy), 0);
    run_sweep(0, 1'b0, cyc);
    check("midrst_cycles", cyc, NVEC * CPV);
    check("midrst_pass", int'(pass), 1);

    // start pulsed repeatedly while busy is ignored
    run_sweep(0, 1'b1, cyc);
    check("poke_cycles", cyc, NVEC * CPV);
    check("poke_pass", int'(pass), 1);
    check("poke_err", int'(err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
